// File: rtl/if_pipe_skid_reg_pkg.sv
// Shared pipeline definitions: the entry-storage state encoding and the default NOP fill.
package if_pipe_skid_reg_pkg;

    // The state value is also the occupancy (0, 1 or 2 held entries).
    typedef logic [1:0] state_t;

    localparam state_t EMPTY = 2'd0;
    localparam state_t ONE   = 2'd1;
    localparam state_t TWO   = 2'd2;

    // The default NOP is all-zero at any instruction width.
    localparam logic NOP_FILL_BIT = 1'b0;

endpackage

// File: rtl/if_pipe_skid_reg_if.sv
// Valid/ready pipeline link that carries one {PC, instruction} entry per beat.
interface if_pipe_skid_reg_if #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 32
);
    logic               valid;
    logic               ready;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;

    modport master (output valid, output pc, output instr, input ready);
    modport slave  (input valid, input pc, input instr, output ready);
endinterface

// File: rtl/if_pipe_skid_reg_sat_counter.sv
// Saturating up-counter. Reset clears it asynchronously.
// It counts one step on each enabled edge and then holds at all-ones.
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    // Count enabled edges and stop at the maximum value instead of wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/if_pipe_skid_reg.sv
// Pipeline register with a two-entry skid buffer between two stages.
// The upstream ready is registered, so it never sees downstream ready combinationally.
// The block also supports hold, flush squash, NOP on empty and a bubble-cycle statistic.
//
// state | meaning
// EMPTY | nothing held, output shows PC 0 / NOP
// ONE   | main (head) register valid
// TWO   | main and skid registers valid, upstream stalled
module if_pipe_skid_reg
    import if_pipe_skid_reg_pkg::*;
#(
    parameter int unsigned        PC_W      = 32,
    parameter int unsigned        INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_VALUE = {INSTR_W{NOP_FILL_BIT}},
    parameter int unsigned        CNT_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_hold,
    if_pipe_skid_reg_if.slave    i_up,
    if_pipe_skid_reg_if.master   o_dn,
    output logic [1:0]           o_occupancy,
    output logic [CNT_W-1:0]     o_bubble_cnt
);
    state_t             r_state;
    state_t             w_next;
    logic               r_in_ready;

    logic [PC_W-1:0]    r_main_pc;
    logic [INSTR_W-1:0] r_main_instr;
    logic [PC_W-1:0]    r_skid_pc;
    logic [INSTR_W-1:0] r_skid_instr;

    logic               w_take;
    logic               w_give;
    logic               w_out_valid;
    logic               w_load_main_in;
    logic               w_load_main_skid;
    logic               w_load_skid_in;

    logic [PC_W-1:0]    w_out_pc;
    logic [INSTR_W-1:0] w_out_instr;
    logic [1:0]         w_occupancy;

    assign w_out_valid = (r_state != EMPTY);
    assign w_take      = i_up.valid & r_in_ready;
    assign w_give      = w_out_valid & o_dn.ready & ~i_hold;

    // Register the state. Ready is computed from the next state, so it is a flop output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != TWO);
        end
    end

    // Compute the next state and the load enables of the entry registers. Flush overrides everything.
    always_comb begin
        w_next           = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid_in   = 1'b0;
        if (i_flush) begin
            w_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_take) begin
                        w_next         = ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (w_take && w_give) begin
                        w_load_main_in = 1'b1;
                    end else if (w_take) begin
                        w_next         = TWO;
                        w_load_skid_in = 1'b1;
                    end else if (w_give) begin
                        w_next = EMPTY;
                    end
                end
                TWO: begin
                    if (w_give) begin
                        w_next           = ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_next = EMPTY;
            endcase
        end
    end

    // Update the entry register pair. A flush clears both registers to PC 0 / NOP.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_main_pc    <= '0;
            r_main_instr <= NOP_VALUE;
            r_skid_pc    <= '0;
            r_skid_instr <= NOP_VALUE;
        end else if (i_flush) begin
            r_main_pc    <= '0;
            r_main_instr <= NOP_VALUE;
            r_skid_pc    <= '0;
            r_skid_instr <= NOP_VALUE;
        end else begin
            if (w_load_main_in) begin
                r_main_pc    <= i_up.pc;
                r_main_instr <= i_up.instr;
            end else if (w_load_main_skid) begin
                r_main_pc    <= r_skid_pc;
                r_main_instr <= r_skid_instr;
            end
            if (w_load_skid_in) begin
                r_skid_pc    <= i_up.pc;
                r_skid_instr <= i_up.instr;
            end
        end
    end

    // Drive outputs from the head register only. Show PC 0 / NOP when no entry is held.
    // The head keeps stale data after it drains, so the output is masked with valid.
    always_comb begin
        w_occupancy = r_state;
        w_out_pc    = '0;
        w_out_instr = NOP_VALUE;
        if (w_out_valid) begin
            w_out_pc    = r_main_pc;
            w_out_instr = r_main_instr;
        end
    end

    assign i_up.ready  = r_in_ready;
    assign o_dn.valid  = w_out_valid;
    assign o_dn.pc     = w_out_pc;
    assign o_dn.instr  = w_out_instr;
    assign o_occupancy = w_occupancy;

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (~w_out_valid),
        .o_cnt (o_bubble_cnt)
    );
endmodule

// File: tb/tb_if_pipe_skid_reg.sv
// Directed bench for if_pipe_skid_reg with a FIFO scoreboard of expected head entries.
module tb_if_pipe_skid_reg;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        hold;
    logic [1:0]  occ;
    logic [15:0] bub;
    logic [1:0]  occ4;
    logic [3:0]  cnt4;

    if_pipe_skid_reg_if #(.PC_W(32), .INSTR_W(32)) up_if ();
    if_pipe_skid_reg_if #(.PC_W(32), .INSTR_W(32)) dn_if ();
    if_pipe_skid_reg_if #(.PC_W(32), .INSTR_W(32)) u4_if ();
    if_pipe_skid_reg_if #(.PC_W(32), .INSTR_W(32)) d4_if ();

    if_pipe_skid_reg #(.PC_W(32), .INSTR_W(32), .NOP_VALUE(NOP), .CNT_W(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (flush),
        .i_hold       (hold),
        .i_up         (up_if),
        .o_dn         (dn_if),
        .o_occupancy  (occ),
        .o_bubble_cnt (bub)
    );

    if_pipe_skid_reg #(.PC_W(32), .INSTR_W(32), .NOP_VALUE(NOP), .CNT_W(4)) dut4 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (1'b0),
        .i_hold       (1'b0),
        .i_up         (u4_if),
        .o_dn         (d4_if),
        .o_occupancy  (occ4),
        .o_bubble_cnt (cnt4)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] q[$];
    int          m_cnt;
    logic [15:0] m_bub;
    logic        last_take;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0] ^ 16'hBEEF, pc[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        up_if.valid = v;
        up_if.pc    = pc;
        up_if.instr = instr_of(pc);
    endtask

    task automatic observe();
        chk("in_ready", 64'(up_if.ready), 64'(m_cnt != 2));
        chk("out_valid", 64'(dn_if.valid), 64'(m_cnt != 0));
        chk("occupancy", 64'(occ), 64'(m_cnt));
        chk("bubble_cnt", 64'(bub), 64'(m_bub));
        if (m_cnt != 0) begin
            chk("out_pc", 64'(dn_if.pc), 64'(q[0][63:32]));
            chk("out_instr", 64'(dn_if.instr), 64'(q[0][31:0]));
        end else begin
            chk("out_pc_empty", 64'(dn_if.pc), 64'd0);
            chk("out_instr_empty", 64'(dn_if.instr), 64'(NOP));
        end
    endtask

    task automatic advance();
        logic take;
        logic give;
        take = up_if.valid & (m_cnt != 2);
        give = (m_cnt != 0) & dn_if.ready & ~hold;
        if (m_cnt == 0 && m_bub != 16'hFFFF) m_bub++;
        if (give) void'(q.pop_front());
        if (flush) q.delete();
        else if (take) q.push_back({up_if.pc, up_if.instr});
        last_take = take & ~flush;
        m_cnt = q.size();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step();
        observe();
        advance();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; hold = 1'b0;
        drive(1'b0, 32'h0);
        dn_if.ready = 1'b0;
        u4_if.valid = 1'b0; u4_if.pc = '0; u4_if.instr = '0;
        d4_if.ready = 1'b0;
        m_cnt = 0; m_bub = '0; last_take = 1'b0;

        // Reset values.
        #12;
        observe();
        chk("rst_cnt4", 64'(cnt4), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Counter saturation on the 4-bit instance.
        repeat (20) step();
        chk("sat_cnt4", 64'(cnt4), 64'd15);
        repeat (3) step();
        chk("sat_cnt4_hold", 64'(cnt4), 64'd15);

        // Fill to TWO, then apply an asynchronous reset between edges.
        dn_if.ready = 1'b0;
        drive(1'b1, 32'h4); step();
        drive(1'b1, 32'h8); step();
        drive(1'b0, 32'h0);
        observe();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(dn_if.valid), 64'd0);
        chk("arst_instr", 64'(dn_if.instr), 64'(NOP));
        chk("arst_pc", 64'(dn_if.pc), 64'd0);
        chk("arst_occ", 64'(occ), 64'd0);
        chk("arst_ready", 64'(up_if.ready), 64'd1);
        chk("arst_bub", 64'(bub), 64'd0);
        q.delete(); m_cnt = 0; m_bub = '0;
        @(negedge clk);
        rst = 1'b0;

        // Streaming with out_ready held high.
        dn_if.ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i * 4)); step();
        end
        drive(1'b0, 32'h0);
        repeat (2) step();

        // Backpressure: 0x18 must wait until space frees.
        dn_if.ready = 1'b0;
        drive(1'b1, 32'h10); step();
        drive(1'b1, 32'h14); step();
        drive(1'b1, 32'h18);
        repeat (2) step();
        dn_if.ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (last_take) break;
        end
        drive(1'b0, 32'h0);
        repeat (3) step();

        // Hold blocks give but not take.
        drive(1'b1, 32'h20); step();
        hold = 1'b1;
        drive(1'b1, 32'h24); step();
        drive(1'b0, 32'h0); step();
        hold = 1'b0;
        repeat (3) step();

        // Flush beats a simultaneous take.
        dn_if.ready = 1'b0;
        drive(1'b1, 32'h30); step();
        drive(1'b1, 32'h34); step();
        drive(1'b1, 32'h38); flush = 1'b1; step();
        flush = 1'b0; drive(1'b0, 32'h0);
        repeat (3) step();

        // Flush while the head is being given.
        dn_if.ready = 1'b1;
        drive(1'b1, 32'h40); step();
        drive(1'b1, 32'h44); flush = 1'b1; step();
        flush = 1'b0; drive(1'b0, 32'h0);
        repeat (2) step();

        // Mixed traffic.
        for (int i = 0; i < 80; i++) begin
            drive(1'($urandom_range(0, 1)), 32'h100 + 32'(i * 4));
            dn_if.ready = 1'($urandom_range(0, 1));
            hold  = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 15) == 0);
            step();
        end
        drive(1'b0, 32'h0); hold = 1'b0; flush = 1'b0; dn_if.ready = 1'b1;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
